bird_physics: RTL and testbench
===============================

BIRD_PHYSICS -- requirements
Module: bird_physics

Interface
REQ-001 SHALL have parameter Y_START, 240, bird row loaded on game start.
REQ-002 SHALL have parameter Y_MAX, 464, ground row (bird top when landed).
REQ-003 SHALL have parameter GRAVITY, 1, velocity increment per tick.
REQ-004 SHALL have parameter FLAP_VEL, -8, velocity loaded on flap (signed).
REQ-005 SHALL have parameter V_MAX, 8, maximum downward velocity.
REQ-006 SHALL have port clk  input  1  system clock; the block uses one clock, clk.
REQ-007 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port tick  input  1  10 Hz square-wave game clock, level, synchronous to clk.
REQ-009 SHALL have port flap  input  1  raw flap button, asynchronous level.
REQ-010 SHALL have port start  input  1  start/restart request, one-cycle pulse.
REQ-011 SHALL have port collide  input  1  pipe collision flag, level.
REQ-012 SHALL have port bird_y  output  10  bird row, unsigned.
REQ-013 SHALL have port vel  output  6  bird velocity, two's complement, positive = down.
REQ-014 SHALL have port state  output  2  IDLE=0, FLY=1, DEAD=2, OVER=3.
REQ-015 SHALL have port frame_upd  output  1  one-cycle pulse on each applied physics update.
REQ-016 SHALL have port game_over  output  1  high while state==OVER.

Function
REQ-017 SHALL pass flap through a 2-FF synchronizer, then detect its rising edge.
REQ-018 SHALL set flap_pend on a synchronized flap rising edge in FLY; flap_pend clears when consumed by a tick; flap edges in IDLE, DEAD, OVER are discarded.
REQ-019 SHALL detect a tick rising edge as tick==1 and tick_prev==0, with tick_prev registered every cycle.
REQ-020 SHALL, in IDLE, on start: bird_y<=Y_START, vel<=0, flap_pend<=0, state<=FLY, next cycle.
REQ-021 SHALL, in FLY on tick edge: vel_n = FLAP_VEL if flap_pend (or flap edge in the same cycle) else min(vel+GRAVITY, V_MAX); y_n = bird_y + vel_n, computed 11-bit signed.
REQ-022 SHALL clamp y_n<0 to bird_y=0, vel=0, state stays FLY (ceiling clamp).
REQ-023 SHALL, on y_n>=Y_MAX, set bird_y=Y_MAX, vel=0, state<=OVER.
REQ-024 SHALL, in FLY, on collide==1 (any cycle), go to DEAD next cycle; collide takes priority over a same-cycle tick update, which is then not applied.
REQ-025 SHALL, in DEAD on tick edge, apply gravity only (flap ignored), same ground rule as REQ-023.
REQ-026 SHALL, in OVER, hold bird_y/vel; start returns to IDLE (bird_y<=Y_START, vel<=0).
REQ-027 SHALL ignore start in FLY and DEAD.
REQ-028 SHALL pulse frame_upd for exactly the cycle after each tick edge applied in FLY or DEAD; never in IDLE/OVER.
REQ-029 SHALL produce registered outputs only; update latency one clk after the tick edge.

Reset
REQ-030 SHALL on clr: state=IDLE, bird_y=Y_START, vel=0, flap_pend=0, frame_upd=0, game_over=0, synchronizer FFs=0.
REQ-031 SHALL reset tick_prev to 1, matching the upstream 10 Hz generator's reset level, so no spurious edge follows reset.
REQ-032 SHALL let clr override all other inputs in the same cycle, including mid-FLY.

Configuration
REQ-033 SHALL, with BIRD_CEILING_KILL_EN defined, treat y_n<0 in FLY as bird_y=0, vel=0, state<=DEAD; without it, REQ-022 clamping applies.

Verification
REQ-034 SHALL test reset then start: state=FLY, bird_y=240, vel=0; three tick edges, no flap -> vel 1,2,3; bird_y 241,243,246.
REQ-035 SHALL test flap pulse between ticks at vel=3, bird_y=246 -> next tick vel=-8, bird_y=238, flap_pend cleared.
REQ-036 SHALL test falling from bird_y=460, vel=8 -> next tick bird_y=464, state=OVER, game_over=1; start -> IDLE, bird_y=240.
REQ-037 SHALL test collide and tick edge in the same cycle in FLY -> state=DEAD, bird_y unchanged; subsequent flaps ignored until OVER.
REQ-038 SHALL test bird_y=4, flap -> bird_y=0, vel=0, FLY (macro off) or DEAD (BIRD_CEILING_KILL_EN on).
REQ-039 SHALL test clr asserted mid-FLY with tick held high -> IDLE, no frame_upd in the following cycles until a fresh tick rising edge.

Source files
------------

// File: rtl/bird_physics.sv
// bird_physics: tick-driven vertical bird physics (gravity, flap, ceiling/ground, death).
// Optional macro BIRD_CEILING_KILL_EN: hitting the ceiling in FLY kills the bird instead of clamping.
module bird_physics #(
    parameter int Y_START  = 240,
    parameter int Y_MAX    = 464,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int V_MAX    = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       flap,
    input  logic       start,
    input  logic       collide,
    output logic [9:0] bird_y,
    output logic [5:0] vel,
    output logic [1:0] state,
    output logic       frame_upd,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2,
        OVER = 2'd3
    } state_e;

    localparam logic signed [10:0] GRAV_S    = 11'(GRAVITY);
    localparam logic signed [10:0] FLAP_S    = 11'(FLAP_VEL);
    localparam logic signed [10:0] VMAX_S    = 11'(V_MAX);
    localparam logic signed [10:0] YMAX_S    = 11'(Y_MAX);
    localparam logic [9:0]         Y_START_U = 10'(Y_START);
    localparam logic [9:0]         Y_MAX_U   = 10'(Y_MAX);

    state_e     state_q, state_d;
    logic [9:0] bird_y_q, bird_y_d;
    logic [5:0] vel_q, vel_d;
    logic       flap_pend_q, flap_pend_d;
    logic       frame_upd_q, frame_upd_d;
    logic       game_over_q, game_over_d;
    logic       flap_s1_q, flap_s2_q, flap_prev_q;
    logic       tick_prev_q;

    logic              flap_edge, tick_edge;
    logic              hit_ceil, hit_ground;
    logic signed [10:0] vel_ext, vel_grav, vel_n, y_n;

    // Candidate physics step, evaluated every cycle; only committed on an applied tick edge.
    always_comb begin
        flap_edge = flap_s2_q & ~flap_prev_q;
        tick_edge = tick & ~tick_prev_q;
        vel_ext   = {{5{vel_q[5]}}, vel_q};
        vel_grav  = vel_ext + GRAV_S;
        if (vel_grav > VMAX_S) begin
            vel_grav = VMAX_S;
        end
        vel_n      = (state_q == FLY && (flap_pend_q || flap_edge)) ? FLAP_S : vel_grav;
        y_n        = $signed({1'b0, bird_y_q}) + vel_n;
        hit_ceil   = (y_n < 11'sd0);
        hit_ground = !hit_ceil && (y_n >= YMAX_S);
    end

    always_comb begin
        state_d     = state_q;
        bird_y_d    = bird_y_q;
        vel_d       = vel_q;
        flap_pend_d = flap_pend_q;
        frame_upd_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FLY;
                    bird_y_d    = Y_START_U;
                    vel_d       = '0;
                    flap_pend_d = 1'b0;
                end
            end
            FLY: begin
                if (collide) begin
                    state_d = DEAD;
                end else if (tick_edge) begin
                    frame_upd_d = 1'b1;
                    flap_pend_d = 1'b0;
                    if (hit_ceil) begin
                        bird_y_d = '0;
                        vel_d    = '0;
`ifdef BIRD_CEILING_KILL_EN
                        state_d  = DEAD;
`else
                        state_d  = FLY;
`endif
                    end else if (hit_ground) begin
                        bird_y_d = Y_MAX_U;
                        vel_d    = '0;
                        state_d  = OVER;
                    end else begin
                        bird_y_d = y_n[9:0];
                        vel_d    = vel_n[5:0];
                    end
                end else if (flap_edge) begin
                    flap_pend_d = 1'b1;
                end
            end
            DEAD: begin
                if (tick_edge) begin
                    frame_upd_d = 1'b1;
                    if (hit_ceil) begin
                        bird_y_d = '0;
                        vel_d    = '0;
                    end else if (hit_ground) begin
                        bird_y_d = Y_MAX_U;
                        vel_d    = '0;
                        state_d  = OVER;
                    end else begin
                        bird_y_d = y_n[9:0];
                        vel_d    = vel_n[5:0];
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_d  = IDLE;
                    bird_y_d = Y_START_U;
                    vel_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_over_d = (state_d == OVER);
    end

    // tick_prev resets high to match the upstream tick generator, so no edge follows reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            bird_y_q    <= Y_START_U;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            frame_upd_q <= 1'b0;
            game_over_q <= 1'b0;
            flap_s1_q   <= 1'b0;
            flap_s2_q   <= 1'b0;
            flap_prev_q <= 1'b0;
            tick_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            flap_pend_q <= flap_pend_d;
            frame_upd_q <= frame_upd_d;
            game_over_q <= game_over_d;
            flap_s1_q   <= flap;
            flap_s2_q   <= flap_s1_q;
            flap_prev_q <= flap_s2_q;
            tick_prev_q <= tick;
        end
    end

    assign bird_y    = bird_y_q;
    assign vel       = vel_q;
    assign state     = state_q;
    assign frame_upd = frame_upd_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: vector table, directed corner sequences and random stimulus against a reference model.
module tb_bird_physics;

    localparam int YS = 240;
    localparam int YM = 464;
`ifdef BIRD_CEILING_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr, tick, flap, start, collide;
    logic [9:0] bird_y;
    logic [5:0] vel;
    logic [1:0] state;
    logic       frame_upd, game_over;

    always #5 clk = ~clk;

    bird_physics #(
        .Y_START (240),
        .Y_MAX   (464),
        .GRAVITY (1),
        .FLAP_VEL(-8),
        .V_MAX   (8)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .tick     (tick),
        .flap     (flap),
        .start    (start),
        .collide  (collide),
        .bird_y   (bird_y),
        .vel      (vel),
        .state    (state),
        .frame_upd(frame_upd),
        .game_over(game_over)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: game state as plain integers, flap history as sampled levels.
    int       m_st, m_y, m_v;
    bit       m_pend, m_fu, m_tprev;
    bit [2:0] fh;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int fall(int v);
        return (v + 1 > 8) ? 8 : v + 1;
    endfunction

    function automatic void land(int nv, bit flying);
        int ny;
        ny   = m_y + nv;
        m_fu = 1'b1;
        if (ny < 0) begin
            m_y = 0; m_v = 0;
            if (flying && KILL) m_st = 2;
        end else if (ny >= YM) begin
            m_y = YM; m_v = 0; m_st = 3;
        end else begin
            m_y = ny; m_v = nv;
        end
    endfunction

    function automatic void model_step();
        bit fe, te;
        if (clr) begin
            m_st = 0; m_y = YS; m_v = 0; m_pend = 0; m_fu = 0; m_tprev = 1; fh = 3'b000;
            return;
        end
        fe   = fh[1] && !fh[2];
        te   = tick && !m_tprev;
        m_fu = 1'b0;
        case (m_st)
            0: if (start) begin m_st = 1; m_y = YS; m_v = 0; m_pend = 0; end
            1: begin
                if (collide) m_st = 2;
                else if (te) begin
                    int nv;
                    nv = (m_pend || fe) ? -8 : fall(m_v);
                    m_pend = 0;
                    land(nv, 1'b1);
                end else if (fe) m_pend = 1;
            end
            2: if (te) land(fall(m_v), 1'b0);
            default: if (start) begin m_st = 0; m_y = YS; m_v = 0; end
        endcase
        m_tprev = tick;
        fh = {fh[1:0], flap};
    endfunction

    function automatic void check_model();
        chk("model.state", int'(state), m_st);
        chk("model.bird_y", int'(bird_y), m_y);
        chk("model.vel", int'($signed(vel)), m_v);
        chk("model.frame_upd", int'(frame_upd), int'(m_fu));
        chk("model.game_over", int'(game_over), (m_st == 3) ? 1 : 0);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
        check_model();
    endtask

    task automatic tick_once(bit do_flap);
        if (do_flap) begin
            flap = 1'b1; step();
            flap = 1'b0; step(); step(); step();
        end
        tick = 1'b1; step();
        tick = 1'b0; step();
    endtask

    task automatic start_game();
        clr = 1'b1; step();
        clr = 1'b0; start = 1'b1; step();
        start = 1'b0; step();
    endtask

    typedef struct {
        bit c, s, t, f, k;
        int st, y, v;
        bit fu;
    } vec_t;

    vec_t tbl[14];

    initial begin
        clr = 1'b1; tick = 1'b0; flap = 1'b0; start = 1'b0; collide = 1'b0;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 240,  0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 1, 240,  0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 240,  0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, 241,  1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 241,  1, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 1, 243,  2, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 243,  2, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 1, 246,  3, 1};
        tbl[8]  = '{0, 0, 0, 1, 0, 1, 246,  3, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 246,  3, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 246,  3, 0};
        tbl[11] = '{0, 0, 1, 0, 0, 1, 238, -8, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 238, -8, 0};
        tbl[13] = '{0, 0, 1, 0, 0, 1, 231, -7, 1};

        for (int i = 0; i < 14; i++) begin
            clr = tbl[i].c; start = tbl[i].s; tick = tbl[i].t; flap = tbl[i].f; collide = tbl[i].k;
            step();
            chk($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d.bird_y", i), int'(bird_y), tbl[i].y);
            chk($sformatf("vec%0d.vel", i), int'($signed(vel)), tbl[i].v);
            chk($sformatf("vec%0d.frame_upd", i), int'(frame_upd), int'(tbl[i].fu));
        end
        tick = 1'b0; flap = 1'b0;

        // Free fall to the ground, then restart from OVER.
        start_game();
        repeat (31) tick_once(1'b0);
        chk("fall.y460", int'(bird_y), 460);
        chk("fall.v8", int'($signed(vel)), 8);
        tick = 1'b1; step();
        chk("ground.state", int'(state), 3);
        chk("ground.y", int'(bird_y), 464);
        chk("ground.vel", int'($signed(vel)), 0);
        chk("ground.game_over", int'(game_over), 1);
        chk("ground.frame_upd", int'(frame_upd), 1);
        tick = 1'b0; step();
        tick_once(1'b1);
        chk("over.hold_y", int'(bird_y), 464);
        start = 1'b1; step(); start = 1'b0;
        chk("restart.state", int'(state), 0);
        chk("restart.y", int'(bird_y), 240);
        chk("restart.game_over", int'(game_over), 0);

        // Collide and tick edge together: death wins, no update applied.
        start_game();
        tick_once(1'b0);
        tick_once(1'b0);
        tick = 1'b1; collide = 1'b1; step();
        collide = 1'b0;
        chk("collide.state", int'(state), 2);
        chk("collide.y", int'(bird_y), 243);
        chk("collide.frame_upd", int'(frame_upd), 0);
        tick = 1'b0; step();
        tick_once(1'b1);
        chk("dead.flap_ignored_v", int'($signed(vel)), 3);
        chk("dead.flap_ignored_y", int'(bird_y), 246);
        for (int i = 0; i < 100 && state != 2'd3; i++) tick_once(i[0]);
        chk("dead.reaches_over", int'(state), 3);

        // Ceiling: bird at row 4 flapping up.
        start_game();
        tick_once(1'b0);
        tick_once(1'b1);
        tick_once(1'b0);
        tick_once(1'b0);
        chk("ceil.y220", int'(bird_y), 220);
        repeat (27) tick_once(1'b1);
        chk("ceil.y4", int'(bird_y), 4);
        chk("ceil.v-8", int'($signed(vel)), -8);
        tick_once(1'b1);
        chk("ceil.y", int'(bird_y), 0);
        chk("ceil.vel", int'($signed(vel)), 0);
        chk("ceil.state", int'(state), KILL ? 2 : 1);

        // clr mid-FLY with tick held high: no spurious update afterwards.
        start_game();
        tick_once(1'b0);
        tick = 1'b1; step();
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr.state", int'(state), 0);
        chk("clr.frame_upd", int'(frame_upd), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr.hold_no_upd", int'(frame_upd), 0);
        end
        start = 1'b1; step(); start = 1'b0;
        chk("clr.restart_state", int'(state), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("clr.fly_no_upd", int'(frame_upd), 0);
        end
        tick = 1'b0; step();
        tick = 1'b1; step();
        chk("clr.fresh_edge_upd", int'(frame_upd), 1);
        chk("clr.fresh_edge_y", int'(bird_y), 241);
        tick = 1'b0;

        // Random stimulus against the model.
        clr = 1'b1; step(); clr = 1'b0;
        begin
            int half;
            half = 3;
            for (int i = 0; i < 4000; i++) begin
                if (half == 0) begin
                    tick = ~tick;
                    half = $urandom_range(6, 2);
                end
                half--;
                if ($urandom_range(7, 0) == 0) flap = ~flap;
                start   = ($urandom_range(24, 0) == 0);
                collide = ($urandom_range(149, 0) == 0);
                clr     = ($urandom_range(399, 0) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
